// File: rtl/lagrange_interpolate_pkg.sv
// lagrange_interpolate_pkg
// Shared prime-field definitions for the interpolator: field width and
// modulus, the FSM state type, modular add/sub helpers, an elaboration-time
// modular multiply, and the inverse-factorial constant function.
// No ports (package).

`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

package lagrange_interpolate_pkg;

  localparam int NW = `F_NBITS;
  localparam logic [NW-1:0] F_Q = `F_Q;

  typedef logic [NW-1:0] fe_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIFF = 3'd1,
    S_CONV = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_e;

  function automatic fe_t f_add(input fe_t a, input fe_t b);
    logic [NW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
    return s[NW-1:0];
  endfunction

  // a - b mod q; when a < b, a + (q - b) stays below q and cannot overflow.
  function automatic fe_t f_sub(input fe_t a, input fe_t b);
    if (a >= b) return a - b;
    else        return a + (F_Q - b);
  endfunction

  function automatic fe_t f_mul_const(input fe_t a, input fe_t b);
    logic [2*NW-1:0] p;
    p = {{NW{1'b0}}, a} * {{NW{1'b0}}, b};
    p = p % {{NW{1'b0}}, F_Q};
    return p[NW-1:0];
  endfunction

  function automatic fe_t f_pow(input fe_t base, input fe_t e);
    fe_t r;
    r = fe_t'(1);
    for (int i = NW - 1; i >= 0; i--) begin
      r = f_mul_const(r, r);
      if (e[i]) r = f_mul_const(r, base);
    end
    return r;
  endfunction

  // (j!)^-1 mod q via Fermat: x^(q-2) = x^-1 for prime q.
  function automatic fe_t f_invfact(input int j);
    fe_t fact;
    fact = fe_t'(1);
    for (int k = 2; k <= j; k++) fact = f_mul_const(fact, fe_t'(k));
    return f_pow(fact, F_Q - fe_t'(2));
  endfunction

endpackage

// File: rtl/lagrange_interpolate_field_mul_mod.sv
// field_mul_mod
// Modular multiplier with a one-cycle fixed latency: a full 2*NW product is
// reduced mod q and registered; vout follows vin by exactly one cycle.
// Ports: clk, rstb (sync active-high reset), a/b operands, vin issue strobe,
//        p registered product, vout result-valid strobe.

module field_mul_mod
  import lagrange_interpolate_pkg::*;
(
  input  logic          clk,
  input  logic          rstb,
  input  logic [NW-1:0] a,
  input  logic [NW-1:0] b,
  input  logic          vin,
  output logic [NW-1:0] p,
  output logic          vout
);

  logic [2*NW-1:0] prod_s;
  logic [NW-1:0]   p_d, p_q;
  logic            vout_d, vout_q;

  always_comb begin
    prod_s = {{NW{1'b0}}, a} * {{NW{1'b0}}, b};
    p_d    = NW'(prod_s % {{NW{1'b0}}, F_Q});
    vout_d = vin;
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      p_q    <= '0;
      vout_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      vout_q <= vout_d;
    end
  end

  assign p    = p_q;
  assign vout = vout_q;

endmodule

// File: rtl/lagrange_interpolate.sv
// lagrange_interpolate
// Turns npoints samples y_i = P(i) into monomial coefficients c_0..c_{n-1}
// mod q: forward differences, scaling by 1/j!, then Newton-to-monomial
// conversion by Horner, one modular multiply at a time.
// Ports: clk, rstb (sync active-high reset), en start request (idle only),
//        yi[npoints] samples, c_wren/c_data coefficient write stream (c_0
//        first), ready (idle), ready_pulse (one cycle after last write).
// LATENCY: rising edges from the edge that samples en to the edge that
//   raises ready_pulse: (n-1) diff passes + 2n scaling + 2n(n-1) Horner
//   + n emit + 1 done = 2n^2 + 2n.

module lagrange_interpolate
  import lagrange_interpolate_pkg::*;
#(
  parameter int npoints = 3
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          en,
  input  logic [NW-1:0] yi [npoints],
  output logic          c_wren,
  output logic [NW-1:0] c_data,
  output logic          ready,
  output logic          ready_pulse
);

  localparam int IW = $clog2(npoints);
  localparam logic [IW-1:0] LAST = IW'(npoints - 1);
  localparam int LATENCY = 2 * npoints * npoints + 2 * npoints;

  state_e        state_d, state_q;
  fe_t           y_d [npoints];
  fe_t           y_q [npoints];
  fe_t           c_d [npoints];
  fe_t           c_q [npoints];
  fe_t           p_d [npoints];
  fe_t           p_q [npoints];
  logic [IW-1:0] idx_d, idx_q, j_d, j_q;
  logic          scale_d, scale_q, wait_d, wait_q;
  logic          c_wren_d, c_wren_q, ready_d, ready_q, ready_pulse_d, ready_pulse_q;
  fe_t           c_data_d, c_data_q;
  fe_t           invfact_s [npoints];
  fe_t           mul_a_s, mul_b_s, mul_p_s;
  logic          mul_vin_s, mul_vout_s;

  for (genvar g = 0; g < npoints; g++) begin : g_invfact
    localparam fe_t IF_VAL = f_invfact(g);
    assign invfact_s[g] = IF_VAL;
  end

  field_mul_mod u_mul (
    .clk  (clk),
    .rstb (rstb),
    .a    (mul_a_s),
    .b    (mul_b_s),
    .vin  (mul_vin_s),
    .p    (mul_p_s),
    .vout (mul_vout_s)
  );

  always_comb begin
    state_d = state_q;
    y_d = y_q;
    c_d = c_q;
    p_d = p_q;
    idx_d = idx_q;
    j_d = j_q;
    scale_d = scale_q;
    wait_d = wait_q;
    c_wren_d = 1'b0;
    c_data_d = c_data_q;
    ready_d = ready_q;
    ready_pulse_d = 1'b0;
    mul_a_s = '0;
    mul_b_s = '0;
    mul_vin_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          y_d = yi;
          ready_d = 1'b0;
          j_d = IW'(1);
          idx_d = '0;
          scale_d = 1'b0;
          wait_d = 1'b0;
          state_d = S_DIFF;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_DIFF: begin
        if (!scale_q) begin
          // Pass j: all entries at index >= j become differences of old values,
          // leaving y[j] = delta^j y_0 after pass j.
          for (int i = 1; i < npoints; i++) begin
            if (IW'(i) >= j_q) y_d[i] = f_sub(y_q[i], y_q[i-1]);
            else               y_d[i] = y_q[i];
          end
          if (j_q == LAST) begin
            scale_d = 1'b1;
            idx_d = '0;
          end else begin
            j_d = j_q + IW'(1);
          end
        end else if (!wait_q) begin
          mul_a_s = y_q[idx_q];
          mul_b_s = invfact_s[idx_q];
          mul_vin_s = 1'b1;
          wait_d = 1'b1;
        end else if (mul_vout_s) begin
          y_d[idx_q] = mul_p_s;
          wait_d = 1'b0;
          if (idx_q == LAST) begin
            // Horner seed: c = [a_{n-1}]
            for (int k = 0; k < npoints; k++) c_d[k] = '0;
            c_d[0] = mul_p_s;
            j_d = IW'(npoints - 2);
            idx_d = '0;
            state_d = S_CONV;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          wait_d = 1'b1;
        end
      end
      S_CONV: begin
        if (!wait_q) begin
          mul_a_s = c_q[idx_q];
          mul_b_s = fe_t'(j_q);
          mul_vin_s = 1'b1;
          wait_d = 1'b1;
        end else if (mul_vout_s) begin
          p_d[idx_q] = mul_p_s;
          wait_d = 1'b0;
          if (idx_q == LAST) begin
            // c'_k = c_{k-1} - j*c_k, c'_0 = a_j - j*c_0; the last product
            // is still on the multiplier output, not yet in p_q.
            c_d[0] = f_sub(y_q[j_q], p_q[0]);
            for (int k = 1; k < npoints - 1; k++) c_d[k] = f_sub(c_q[k-1], p_q[k]);
            c_d[npoints-1] = f_sub(c_q[npoints-2], mul_p_s);
            idx_d = '0;
            if (j_q == '0) state_d = S_EMIT;
            else           j_d = j_q - IW'(1);
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          wait_d = 1'b1;
        end
      end
      S_EMIT: begin
        c_wren_d = 1'b1;
        c_data_d = c_q[idx_q];
        if (idx_q == LAST) state_d = S_DONE;
        else               idx_d = idx_q + IW'(1);
      end
      S_DONE: begin
        ready_pulse_d = 1'b1;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q       <= S_IDLE;
      y_q           <= '{default: '0};
      c_q           <= '{default: '0};
      p_q           <= '{default: '0};
      idx_q         <= '0;
      j_q           <= '0;
      scale_q       <= 1'b0;
      wait_q        <= 1'b0;
      c_wren_q      <= 1'b0;
      c_data_q      <= '0;
      ready_q       <= 1'b1;
      ready_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      y_q           <= y_d;
      c_q           <= c_d;
      p_q           <= p_d;
      idx_q         <= idx_d;
      j_q           <= j_d;
      scale_q       <= scale_d;
      wait_q        <= wait_d;
      c_wren_q      <= c_wren_d;
      c_data_q      <= c_data_d;
      ready_q       <= ready_d;
      ready_pulse_q <= ready_pulse_d;
    end
  end

  assign c_wren      = c_wren_q;
  assign c_data      = c_data_q;
  assign ready       = ready_q;
  assign ready_pulse = ready_pulse_q;

endmodule

// File: tb/tb_lagrange_interpolate.sv
// tb_lagrange_interpolate
// Drives a 3-point and a 9-point interpolator; written coefficients are
// captured and checked by evaluating the polynomial at the nodes, plus
// directed coefficient values, latency, pulse and reset behaviour.

module tb_lagrange_interpolate;
  import lagrange_interpolate_pkg::*;

  localparam int N3 = 3;
  localparam int N9 = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstb;
  logic en3, en9;
  fe_t  yi3 [N3];
  fe_t  yi9 [N9];
  logic c_wren3, c_wren9, ready3, ready9, rp3, rp9;
  fe_t  c_data3, c_data9;

  int total = 0;
  int bad = 0;
  fe_t cq3[$];
  fe_t cq9[$];
  fe_t vin [16];

  lagrange_interpolate #(.npoints(N3)) dut3 (
    .clk(clk), .rstb(rstb), .en(en3), .yi(yi3),
    .c_wren(c_wren3), .c_data(c_data3), .ready(ready3), .ready_pulse(rp3)
  );

  lagrange_interpolate #(.npoints(N9)) dut9 (
    .clk(clk), .rstb(rstb), .en(en9), .yi(yi9),
    .c_wren(c_wren9), .c_data(c_data9), .ready(ready9), .ready_pulse(rp9)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Capture the coefficient streams; a write and the completion pulse must never share a cycle.
  always @(negedge clk) begin
    if (c_wren3 === 1'b1) cq3.push_back(c_data3);
    if (c_wren9 === 1'b1) cq9.push_back(c_data9);
    if (c_wren3 === 1'b1 || rp3 === 1'b1) chk("overlap3", {127'd0, c_wren3 & rp3}, 128'd0);
    if (c_wren9 === 1'b1 || rp9 === 1'b1) chk("overlap9", {127'd0, c_wren9 & rp9}, 128'd0);
  end

  function automatic fe_t m_mul(input fe_t a, input fe_t b);
    logic [127:0] p;
    p = 128'(a) * 128'(b);
    return fe_t'(p % 128'(F_Q));
  endfunction

  function automatic fe_t m_add(input fe_t a, input fe_t b);
    return fe_t'((128'(a) + 128'(b)) % 128'(F_Q));
  endfunction

  function automatic fe_t horner(input fe_t c[$], input int x);
    fe_t r;
    r = '0;
    for (int k = c.size() - 1; k >= 0; k--) r = m_add(m_mul(r, fe_t'(x)), c[k]);
    return r;
  endfunction

  function automatic logic rp_of(input int n);
    return (n == N3) ? rp3 : rp9;
  endfunction

  function automatic logic rdy_of(input int n);
    return (n == N3) ? ready3 : ready9;
  endfunction

  function automatic fe_t rnd_fe();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return fe_t'(r % 64'(F_Q));
  endfunction

  // Starts one run from a negedge with vin as samples; with hold, en stays
  // high and yi is scrambled while busy. Ends at the negedge after the pulse.
  task automatic run(input int n, input bit hold);
    int cyc;
    bit busy_ready;
    fe_t res[$];
    if (n == N3) cq3.delete(); else cq9.delete();
    if (n == N3) begin
      for (int i = 0; i < N3; i++) yi3[i] = vin[i];
      en3 = 1'b1;
    end else begin
      for (int i = 0; i < N9; i++) yi9[i] = vin[i];
      en9 = 1'b1;
    end
    @(negedge clk);
    if (!hold) begin en3 = 1'b0; en9 = 1'b0; end
    cyc = 0;
    busy_ready = 1'b0;
    while (rp_of(n) !== 1'b1 && cyc < 2000) begin
      if (hold) begin
        for (int i = 0; i < N3; i++) yi3[i] = rnd_fe();
      end
      if (rdy_of(n) !== 1'b0) busy_ready = 1'b1;
      @(negedge clk);
      cyc++;
    end
    en3 = 1'b0;
    en9 = 1'b0;
    chk("pulse_seen", {127'd0, cyc < 2000}, 128'd1);
    chk("latency", 128'(cyc), 128'(2 * n * n + 2 * n));
    chk("ready_at_pulse", {127'd0, rdy_of(n)}, 128'd1);
    chk("ready_low_busy", {127'd0, busy_ready}, 128'd0);
    if (n == N3) res = cq3; else res = cq9;
    chk("nwrites", 128'(res.size()), 128'(n));
    for (int x = 0; x < n; x++) chk("horner_eval", 128'(horner(res, x)), 128'(vin[x]));
    @(negedge clk);
    chk("pulse_width", {127'd0, rp_of(n)}, 128'd0);
  endtask

  task automatic chk_coef3(input string tag, input fe_t e0, input fe_t e1, input fe_t e2);
    if (cq3.size() == 3) begin
      chk({tag, "_c0"}, 128'(cq3[0]), 128'(e0));
      chk({tag, "_c1"}, 128'(cq3[1]), 128'(e1));
      chk({tag, "_c2"}, 128'(cq3[2]), 128'(e2));
    end else begin
      chk({tag, "_count"}, 128'(cq3.size()), 128'd3);
    end
  endtask

  initial begin
    int cyc;
    bit stray;
    fe_t half;
    rstb = 1'b1;
    en3 = 1'b0;
    en9 = 1'b0;
    for (int i = 0; i < N3; i++) yi3[i] = '0;
    for (int i = 0; i < N9; i++) yi9[i] = '0;
    for (int i = 0; i < 16; i++) vin[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready3", {127'd0, ready3}, 128'd1);
    chk("rst_pulse3", {127'd0, rp3}, 128'd0);
    chk("rst_wren3", {127'd0, c_wren3}, 128'd0);
    chk("rst_data3", 128'(c_data3), 128'd0);
    chk("rst_ready9", {127'd0, ready9}, 128'd1);
    chk("rst_wren9", {127'd0, c_wren9}, 128'd0);
    rstb = 1'b0;
    @(negedge clk);

    // constant
    for (int i = 0; i < N3; i++) vin[i] = fe_t'(5);
    run(N3, 1'b0);
    chk_coef3("const", fe_t'(5), fe_t'(0), fe_t'(0));
    // linear
    for (int i = 0; i < N3; i++) vin[i] = fe_t'(i);
    run(N3, 1'b0);
    chk_coef3("lin", fe_t'(0), fe_t'(1), fe_t'(0));
    // quadratic
    for (int i = 0; i < N3; i++) vin[i] = fe_t'(i * i);
    run(N3, 1'b0);
    chk_coef3("quad", fe_t'(0), fe_t'(0), fe_t'(1));
    // affine
    for (int i = 0; i < N3; i++) vin[i] = fe_t'(2 * i + 7);
    run(N3, 1'b0);
    chk_coef3("affine", fe_t'(7), fe_t'(2), fe_t'(0));
    // field wrap: P = (q-1)(x-1)(x-2)/2, so c_2 = -(1/2)
    vin[0] = F_Q - fe_t'(1);
    vin[1] = '0;
    vin[2] = '0;
    run(N3, 1'b0);
    half = fe_t'((128'(F_Q) + 128'd1) / 128'd2);
    if (cq3.size() == 3) begin
      chk("wrap_c0", 128'(cq3[0]), 128'(F_Q - fe_t'(1)));
      chk("wrap_c2", 128'(cq3[2]), 128'(m_mul(half, F_Q - fe_t'(1))));
    end

    // en held through the run while yi churns
    for (int i = 0; i < N3; i++) vin[i] = rnd_fe();
    run(N3, 1'b1);

    // reset during coefficient emission
    for (int i = 0; i < N3; i++) begin vin[i] = rnd_fe(); yi3[i] = vin[i]; end
    en3 = 1'b1;
    @(negedge clk);
    en3 = 1'b0;
    cyc = 0;
    while (c_wren3 !== 1'b1 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("emit_seen", {127'd0, cyc < 500}, 128'd1);
    rstb = 1'b1;
    @(negedge clk);
    rstb = 1'b0;
    chk("midrst_wren", {127'd0, c_wren3}, 128'd0);
    chk("midrst_ready", {127'd0, ready3}, 128'd1);
    chk("midrst_pulse", {127'd0, rp3}, 128'd0);
    stray = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (rp3 !== 1'b0 || c_wren3 !== 1'b0) stray = 1'b1;
    end
    chk("midrst_quiet", {127'd0, stray}, 128'd0);
    for (int i = 0; i < N3; i++) vin[i] = rnd_fe();
    run(N3, 1'b0);

    // random regression, back-to-back
    for (int r = 0; r < 100; r++) begin
      for (int i = 0; i < N9; i++) vin[i] = rnd_fe();
      run(N9, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
